rr_arbiter_ctrl: RTL and testbench

- Round-robin arbiter/controller that shares a single FSM-style resource among N requesters.
- Accepts level requests, issues a one-hot registered grant, and holds it until the owner signals done, drops its request, or a hold timeout expires.
- Inserts one guard cycle between owners and rotates priority for fairness.
- Sits between requester blocks and the shared resource; grant also drives the resource input mux select (grant_id).

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_arbiter_ctrl.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the round-robin arbiter: FSM state encoding,
// default sizing and the one-hot helper used to build the grant vector.
package arb_pkg;

  // Default number of requesters and maximum grant length.
  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 16;

  // Widest requester count supported; onehot() works at this width and
  // callers truncate to their own N.
  localparam int MAX_N = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    GUARD = 2'd2
  } state_t;

  // Index to one-hot vector at the widest supported requester count.
  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
`timescale 1ns/1ps
// Round-robin winner selection. Purely combinational: scans req starting at
// ptr and wrapping modulo N, returning the first set index and a valid flag.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           valid
);

  // Walk offsets from the farthest to the nearest so the last hit, which
  // overwrites earlier ones, is the requester closest to ptr.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_w = IDW'(idx);
      if (req[idx_w]) begin
        winner = idx_w;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
`timescale 1ns/1ps
// Round-robin arbiter for a single shared resource. Grants one requester at a
// time with a registered one-hot grant, holds it until done, request drop or
// a hold timeout, then inserts one guard cycle and rotates priority.
module rr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset_b,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  // Hold counter only needs to reach MAX_HOLD-1.
  localparam int             HCW       = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

  state_t         state_q,    state_d;
  logic [N-1:0]   grant_q,    grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q,      ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic [IDW-1:0] pick_winner;
  logic           pick_valid;
  logic [2:0]     winner_ext;
  logic           owner_req;
  logic           timeout_c;

  // Winner search is evaluated every cycle but only consumed in IDLE.
  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign winner_ext = 3'(pick_winner);
  assign owner_req  = req[grant_id_q];

  // Next-state, grant and counter logic; release priority is done, then
  // owner dropping its request, then hold timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BUSY;
          grant_d    = N'(onehot(winner_ext));
          grant_id_d = pick_winner;
          hold_cnt_d = '0;
        end
      end

      BUSY: begin
        hold_cnt_d = hold_cnt_q + HCW'(1);
        if (done || !owner_req || (hold_cnt_q == HOLD_LAST)) begin
          // Timeout only counts when neither earlier condition fired.
          timeout_c  = !done && owner_req;
          state_d    = GUARD;
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          ptr_d      = (grant_id_q == ID_LAST) ? '0 : grant_id_q + IDW'(1);
        end
      end

      GUARD: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset clears grant immediately without a clock edge.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == BUSY);
  assign timeout  = timeout_c;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
`timescale 1ns/1ps
// Directed scoreboard bench for rr_arbiter_ctrl: each cycle drives inputs,
// queues the outputs expected in that cycle and compares them mid-cycle.
module tb_rr_arbiter_ctrl;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
  localparam int IDW      = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic           done  = 1'b0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  always #5 clk = ~clk;

  rr_arbiter_ctrl #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .IDW      (IDW)
  ) dut (
    .clock    (clk),
    .reset_b  (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    string          tag;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [IDW-1:0] idx_of(input logic [N-1:0] g);
    idx_of = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) idx_of = IDW'(i);
    end
  endfunction

  task automatic push(input string tag, input logic [N-1:0] g, input logic t);
    exp_t e;
    e.tag      = tag;
    e.grant    = g;
    e.grant_id = idx_of(g);
    e.busy     = (g != '0);
    e.timeout  = t;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d required=1+", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (grant === e.grant) else begin
        bad++;
        $error("FAIL %s grant got=%b required=%b", e.tag, grant, e.grant);
      end
      total++;
      assert (grant_id === e.grant_id) else begin
        bad++;
        $error("FAIL %s grant_id got=%0d required=%0d", e.tag, grant_id, e.grant_id);
      end
      total++;
      assert (busy === e.busy) else begin
        bad++;
        $error("FAIL %s busy got=%b required=%b", e.tag, busy, e.busy);
      end
      total++;
      assert (timeout === e.timeout) else begin
        bad++;
        $error("FAIL %s timeout got=%b required=%b", e.tag, timeout, e.timeout);
      end
    end
  endtask

  // One cycle: entered 1ns after a rising edge, drives inputs, checks the
  // outputs of this cycle 1ns later, then advances past the next edge.
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic d,
                     input logic [N-1:0] eg, input logic et);
    req  = r;
    done = d;
    push(tag, eg, et);
    #1;
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 12 time units with no requests.
    #2;
    push("in_reset", '0, 1'b0);
    check_out();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) cyc("reset_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Round-robin rotation from ptr=0 with all requesters active.
    cyc("rr_arb", 4'b1111, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc("rr_grant", 4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b0);
      cyc("rr_guard", (k == 4) ? 4'b0000 : 4'b1111, 1'b0, 4'b0000, 1'b0);
      cyc("rr_gap",   (k == 4) ? 4'b0000 : 4'b1111, 1'b0, 4'b0000, 1'b0);
    end

    // Single requester, done on the 4th BUSY cycle, then re-grant.
    cyc("single_arb", 4'b0100, 1'b0, 4'b0000, 1'b0);
    repeat (3) cyc("single_hold", 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("single_done",   4'b0100, 1'b1, 4'b0100, 1'b0);
    cyc("single_guard",  4'b0100, 1'b0, 4'b0000, 1'b0);
    cyc("single_gap",    4'b0100, 1'b0, 4'b0000, 1'b0);
    cyc("single_regrant", 4'b0000, 1'b0, 4'b0100, 1'b0);
    cyc("single_drop_g", 4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc("single_drop_i", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Hold timeout: grant lasts MAX_HOLD cycles, timeout in the last only.
    cyc("to_arb", 4'b0001, 1'b0, 4'b0000, 1'b0);
    for (int h = 0; h < MAX_HOLD; h++) begin
      cyc("to_hold", 4'b0001, 1'b0, 4'b0001, (h == MAX_HOLD - 1));
    end
    cyc("to_guard", 4'b0001, 1'b0, 4'b0000, 1'b0);
    cyc("to_gap",   4'b0001, 1'b0, 4'b0000, 1'b0);

    // done coinciding with the last hold cycle suppresses timeout.
    for (int h = 0; h < MAX_HOLD; h++) begin
      cyc("dto_hold", 4'b0001, (h == MAX_HOLD - 1), 4'b0001, 1'b0);
    end
    cyc("dto_guard", 4'b0001, 1'b0, 4'b0000, 1'b0);
    cyc("dto_idle",  4'b0000, 1'b0, 4'b0000, 1'b0);

    // Owner 3 drops its request; ptr wraps to 0 so bit 0 beats bit 3.
    cyc("wrap_arb",   4'b1001, 1'b0, 4'b0000, 1'b0);
    cyc("wrap_hold",  4'b1001, 1'b0, 4'b1000, 1'b0);
    cyc("wrap_drop",  4'b0001, 1'b0, 4'b1000, 1'b0);
    cyc("wrap_guard", 4'b1011, 1'b0, 4'b0000, 1'b0);
    cyc("wrap_gap",   4'b1011, 1'b0, 4'b0000, 1'b0);
    cyc("wrap_grant", 4'b1011, 1'b1, 4'b0001, 1'b0);
    cyc("wrap_g2",    4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc("wrap_i2",    4'b0000, 1'b0, 4'b0000, 1'b0);

    // Asynchronous reset while requester 1 owns the grant.
    cyc("arst_arb", 4'b0010, 1'b0, 4'b0000, 1'b0);
    push("arst_before", 4'b0010, 1'b0);
    #1;
    check_out();
    #1 rst_n = 1'b0;
    #1;
    push("arst_cleared", 4'b0000, 1'b0);
    check_out();
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc("arst_after", 4'b0000, 1'b0, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
